spram_be_init: RTL and testbench
================================

# spram_be_init

Parametrised single-port RAM for the Gigatron core with byte-lane write enables, selectable read latency and a hardware clear sequencer. After reset, or on request, the sequencer fills every word with a deterministic pattern. Host accesses are locked out while it runs. It replaces the fixed 8-bit main-memory RAM and sits between the CPU/bus decoder and the video/loader clients.

## Interface
- ADDR_WIDTH, 15, word-address bits; depth = 2**ADDR_WIDTH.
- DATA_WIDTH, 8, word width in bits.
- LANE_WIDTH, 8, bits per write-enable lane. DATA_WIDTH must be a multiple of LANE_WIDTH, otherwise elaboration fails. LANES = DATA_WIDTH/LANE_WIDTH.
- READ_LATENCY, 0, 0 = combinational read, 1 = registered read. Any other value is an elaboration error.
- FILL_VALUE, '0, word written by the clear sequencer when the LFSR fill is not compiled in.
- clock  in  1  single clock; all state changes on its rising edge.
- reset_n  in  1  reset, asynchronous and active-low.
- clear_req  in  1  single-cycle pulse that starts or restarts a memory clear.
- busy  out  1  high while the clear sequencer owns the array.
- cs  in  1  chip select.
- wren  in  1  write enable.
- be  in  LANES  per-lane write enable.
- address  in  ADDR_WIDTH  word address.
- data  in  DATA_WIDTH  write data.
- q  out  DATA_WIDTH  read data; all-ones when deselected or busy.
- q_valid  out  1  q carries array data.

## Operation
- FSM states:
  - CLEAR: clr_addr counter walks 0 → 2**ADDR_WIDTH-1, writing one full word per cycle.
  - READY: normal host access.
- Transitions:
  - Reset puts the FSM in CLEAR with clr_addr=0. The first word is written on the first rising edge after reset_n deasserts.
  - CLEAR → READY on the edge that writes the last address.
  - READY → CLEAR on the edge where clear_req=1. clr_addr restarts at 0 and the LFSR is reseeded.
  - clear_req=1 while in CLEAR restarts the sweep: clr_addr=0, LFSR reseeded.
- busy = (state==CLEAR), driven combinationally from the state register.
- Host write:
  - On a clock edge with cs & wren & ~busy, lane i is updated from data only where be[i]=1.
  - Writes are ignored while cs=0 or busy=1.
- Host read, READ_LATENCY=0:
  - q = (cs & ~busy) ? mem[address] : all-ones.
  - q_valid = cs & ~busy.
- Host read, READ_LATENCY=1:
  - At each edge, q is registered from the same expression; q_valid is registered from cs & ~busy.
  - Read-first: a simultaneous write to the same address returns the old word.
- Reset values:
  - busy=1.
  - q_valid=0.
  - q=all-ones, both latencies. In latency 0 this follows because busy=1.
- Array contents are not touched by reset itself. The clear sweep defines them.

## Timing
- Clear duration: exactly 2**ADDR_WIDTH cycles from its start edge. busy falls after the edge that writes the last word.
- Host write latency: 1 edge.
- Read latency: 0 or 1 edge, per READ_LATENCY.
- reset_n asserted mid-clear: busy stays 1, q goes all-ones immediately, and the sweep restarts from 0 after release.
- clear_req on the same edge as a host write in READY: the clear wins and the host write is dropped.

## Configuration
- SPRAM_LFSR_FILL_EN defined:
  - Clear writes pseudo-random words, emulating SRAM power-up contents deterministically.
  - 16-bit Galois LFSR, polynomial x^16+x^14+x^13+x^11+1 (taps mask 16'hB400), seed 16'hACE1.
  - The LFSR advances once per word.
  - Each word is the LFSR state replicated and truncated to DATA_WIDTH, so for DATA_WIDTH=8 word 0 = 8'hE1.
- Undefined: every cleared word equals FILL_VALUE and no LFSR logic is generated.

## Structure
- Package spram_pkg holds:
  - state enum (CLEAR, READY);
  - LFSR_SEED and LFSR_TAPS constants;
  - a function that replicates the LFSR state to DATA_WIDTH.
- Sub-module spram_lfsr: 16-bit Galois LFSR with load and step inputs. It is instantiated only under SPRAM_LFSR_FILL_EN.
- The array is a single inferred memory with a lane loop. The clear port and host port are muxed before it: one write port only.

## Test plan
- ADDR_WIDTH=4, FILL_VALUE=8'h00, macro off: release reset → busy=1 for exactly 16 cycles, then 0; reading addresses 0–15 returns 8'h00 with q_valid=1.
- DATA_WIDTH=16, LANE_WIDTH=8: after clear to 16'h0000, write 16'hBEEF with be=2'b01 at address 3 → read returns 16'h00EF; rewrite with be=2'b10 → 16'hBEEF.
- cs=0: q=16'hFFFF and q_valid=0; a write with cs=0, wren=1 to address 3 leaves the contents unchanged on readback.
- READ_LATENCY=1: write 8'h5A to address 2 while reading address 2 (old value 8'h00) → q=8'h00 one edge later, then 8'h5A on the next read.
- clear_req pulsed at clr_addr=7 → busy stays high 16 more cycles after the pulse edge; a host write attempted during busy is absent after the clear.
- Macro on, ADDR_WIDTH=4: word 0 = 8'hE1 and words 1–15 match the reference LFSR sequence. reset_n asserted at clr_addr=5, then released → the same sequence regenerates from word 0.

Source files
------------

// File: rtl/spram_pkg.sv
// rtl/spram_pkg.sv - shared types, LFSR constants and fill helper for spram_be_init
package spram_pkg;

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } spram_state_e;

    localparam logic [15:0] LFSR_SEED      = 16'hACE1;
    localparam logic [15:0] LFSR_TAPS      = 16'hB400;
    // Widest data word the LFSR fill can replicate into.
    localparam int          MAX_DATA_WIDTH = 256;

    // Repeats the 16-bit LFSR state across the widest supported word; the
    // caller keeps the low DATA_WIDTH bits.
    function automatic logic [MAX_DATA_WIDTH-1:0] lfsr_replicate(input logic [15:0] s);
        return {(MAX_DATA_WIDTH / 16){s}};
    endfunction

endpackage

// File: rtl/spram_lfsr.sv
// rtl/spram_lfsr.sv - 16-bit Galois LFSR with load and step controls
//
// Ports:
//   clock, reset_n : clock and asynchronous active-low reset (resets to seed)
//   load           : reload the seed (wins over step)
//   step           : advance one position
//   state          : current LFSR state
module spram_lfsr
    import spram_pkg::*;
(
    input  logic        clock,
    input  logic        reset_n,
    input  logic        load,
    input  logic        step,
    output logic [15:0] state
);

    logic [15:0] state_q;
    logic [15:0] state_d;

    // Right-shifting Galois form: the bit shifted out folds the taps back in.
    always_comb begin
        state_d = state_q;
        if (load) begin
            state_d = LFSR_SEED;
        end else if (step) begin
            state_d = {1'b0, state_q[15:1]} ^ (state_q[0] ? LFSR_TAPS : 16'h0000);
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= LFSR_SEED;
        end else begin
            state_q <= state_d;
        end
    end

    assign state = state_q;

endmodule

// File: rtl/spram_be_init.sv
// rtl/spram_be_init.sv - single-port RAM with byte-lane writes and clear sequencer
//
// Optional feature macro: SPRAM_LFSR_FILL_EN (clear writes an LFSR pattern
// instead of FILL_VALUE).
//
// Ports:
//   clock, reset_n : clock and asynchronous active-low reset
//   clear_req      : pulse that starts or restarts a full-array clear
//   busy           : clear sequencer owns the array
//   cs, wren, be   : chip select, write enable, per-lane write enables
//   address, data  : word address and write data
//   q, q_valid     : read data (all-ones when not valid) and its qualifier
module spram_be_init
    import spram_pkg::*;
#(
    parameter int                    ADDR_WIDTH   = 15,
    parameter int                    DATA_WIDTH   = 8,
    parameter int                    LANE_WIDTH   = 8,
    parameter int                    READ_LATENCY = 0,
    parameter logic [DATA_WIDTH-1:0] FILL_VALUE   = '0
) (
    input  logic                               clock,
    input  logic                               reset_n,
    input  logic                               clear_req,
    output logic                               busy,
    input  logic                               cs,
    input  logic                               wren,
    input  logic [DATA_WIDTH/LANE_WIDTH-1:0]   be,
    input  logic [ADDR_WIDTH-1:0]              address,
    input  logic [DATA_WIDTH-1:0]              data,
    output logic [DATA_WIDTH-1:0]              q,
    output logic                               q_valid
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam int LANES = DATA_WIDTH / LANE_WIDTH;

    if (DATA_WIDTH % LANE_WIDTH != 0) begin : g_bad_lane
        $error("spram_be_init: DATA_WIDTH must be a multiple of LANE_WIDTH");
    end
    if (READ_LATENCY != 0 && READ_LATENCY != 1) begin : g_bad_latency
        $error("spram_be_init: READ_LATENCY must be 0 or 1");
    end

    spram_state_e          state_q, state_d;
    logic [ADDR_WIDTH-1:0] clr_addr_q, clr_addr_d;

    always_comb begin
        state_d    = state_q;
        clr_addr_d = clr_addr_q;
        if (clear_req) begin
            state_d    = CLEAR;
            clr_addr_d = '0;
        end else if (state_q == CLEAR) begin
            clr_addr_d = clr_addr_q + 1'b1;
            if (clr_addr_q == {ADDR_WIDTH{1'b1}}) begin
                state_d = READY;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= CLEAR;
            clr_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            clr_addr_q <= clr_addr_d;
        end
    end

    assign busy = (state_q == CLEAR);

    logic [DATA_WIDTH-1:0] fill_word;

`ifdef SPRAM_LFSR_FILL_EN
    if (DATA_WIDTH > MAX_DATA_WIDTH) begin : g_bad_fill_width
        $error("spram_be_init: DATA_WIDTH too wide for LFSR fill");
    end

    logic [15:0]               lfsr_state;
    logic [MAX_DATA_WIDTH-1:0] lfsr_wide;

    // The LFSR holds the pattern for the word at clr_addr_q; it steps with
    // every clear write and reseeds whenever a sweep (re)starts.
    spram_lfsr u_lfsr (
        .clock   (clock),
        .reset_n (reset_n),
        .load    (clear_req),
        .step    (busy & ~clear_req),
        .state   (lfsr_state)
    );

    assign lfsr_wide = lfsr_replicate(lfsr_state);
    assign fill_word = lfsr_wide[DATA_WIDTH-1:0];
`else
    assign fill_word = FILL_VALUE;
`endif

    // Single write port: the clear sequencer takes it whenever busy. A
    // clear_req in READY drops any host write on the same edge.
    logic                  wr_en;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [DATA_WIDTH-1:0] wr_data;
    logic [LANES-1:0]      wr_be;

    always_comb begin
        wr_en   = busy | (cs & wren & ~clear_req);
        wr_addr = busy ? clr_addr_q : address;
        wr_data = busy ? fill_word  : data;
        wr_be   = busy ? {LANES{1'b1}} : be;
    end

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clock) begin
        for (int i = 0; i < LANES; i++) begin
            if (wr_en && wr_be[i]) begin
                mem[wr_addr][i*LANE_WIDTH +: LANE_WIDTH] <= wr_data[i*LANE_WIDTH +: LANE_WIDTH];
            end
        end
    end

    logic                  rd_en;
    logic [DATA_WIDTH-1:0] rd_word;

    assign rd_en   = cs & ~busy;
    assign rd_word = rd_en ? mem[address] : {DATA_WIDTH{1'b1}};

    if (READ_LATENCY == 1) begin : g_reg_read
        logic [DATA_WIDTH-1:0] q_q, q_d;
        logic                  q_valid_q, q_valid_d;

        // mem is sampled before this edge's write lands, giving read-first.
        always_comb begin
            q_d       = rd_word;
            q_valid_d = rd_en;
        end

        always_ff @(posedge clock or negedge reset_n) begin
            if (!reset_n) begin
                q_q       <= {DATA_WIDTH{1'b1}};
                q_valid_q <= 1'b0;
            end else begin
                q_q       <= q_d;
                q_valid_q <= q_valid_d;
            end
        end

        assign q       = q_q;
        assign q_valid = q_valid_q;
    end else begin : g_comb_read
        assign q       = rd_word;
        assign q_valid = rd_en;
    end

endmodule

// File: tb/tb_spram_be_init.sv
// tb/tb_spram_be_init.sv - randomized self-checking bench for spram_be_init
module tb_spram_be_init;

    localparam int N = 16;

`ifdef SPRAM_LFSR_FILL_EN
    localparam logic [15:0] W0 = 16'hACE1;
    localparam logic [15:0] W1 = 16'hE270;
    localparam logic [15:0] W2 = 16'h7138;
    localparam logic [15:0] W3 = 16'h389C;
`else
    localparam logic [15:0] W0 = 16'h0000;
    localparam logic [15:0] W1 = 16'h0000;
    localparam logic [15:0] W2 = 16'h0000;
    localparam logic [15:0] W3 = 16'h0000;
`endif

    logic        clock     = 1'b0;
    logic        reset_n   = 1'b0;
    logic        clear_req = 1'b0;
    logic        cs        = 1'b0;
    logic        wren      = 1'b0;
    logic [1:0]  be        = 2'b00;
    logic [3:0]  address   = 4'd0;
    logic [15:0] data      = 16'h0000;

    logic        busy0, busy1, qv0, qv1;
    logic [15:0] q0, q1;

    always #5 clock = ~clock;

    spram_be_init #(
        .ADDR_WIDTH(4), .DATA_WIDTH(16), .LANE_WIDTH(8),
        .READ_LATENCY(0), .FILL_VALUE(16'h0000)
    ) dut0 (
        .clock(clock), .reset_n(reset_n), .clear_req(clear_req), .busy(busy0),
        .cs(cs), .wren(wren), .be(be), .address(address), .data(data),
        .q(q0), .q_valid(qv0)
    );

    spram_be_init #(
        .ADDR_WIDTH(4), .DATA_WIDTH(16), .LANE_WIDTH(8),
        .READ_LATENCY(1), .FILL_VALUE(16'h0000)
    ) dut1 (
        .clock(clock), .reset_n(reset_n), .clear_req(clear_req), .busy(busy1),
        .cs(cs), .wren(wren), .be(be), .address(address), .data(data),
        .q(q1), .q_valid(qv1)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Word the clear leaves at index i: the i-th LFSR state or the constant fill.
    function automatic logic [15:0] fill_fn(input int i);
`ifdef SPRAM_LFSR_FILL_EN
        logic [15:0] s;
        s = 16'hACE1;
        for (int k = 0; k < i; k++) begin
            s = s[0] ? ((s >> 1) ^ 16'hB400) : (s >> 1);
        end
        return s;
`else
        return 16'h0000;
`endif
    endfunction

    // Behavioural model: memory contents, remaining clear cycles, and the
    // registered-read expectation.
    logic [15:0] m_mem [N];
    int          m_cnt = N;
    logic [15:0] m_q1  = 16'hFFFF;
    logic        m_qv1 = 1'b0;
    logic        m_b;

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            m_cnt = N;
            m_q1  = 16'hFFFF;
            m_qv1 = 1'b0;
        end else begin
            m_b   = (m_cnt > 0);
            m_qv1 = cs & !m_b;
            m_q1  = m_qv1 ? m_mem[address] : 16'hFFFF;
            if (clear_req) begin
                m_cnt = N;
            end else if (m_b) begin
                m_cnt--;
                if (m_cnt == 0) begin
                    for (int i = 0; i < N; i++) m_mem[i] = fill_fn(i);
                end
            end else if (cs && wren) begin
                if (be[0]) m_mem[address][7:0]  = data[7:0];
                if (be[1]) m_mem[address][15:8] = data[15:8];
            end
        end
    end

    logic        e_busy, e_v0;
    logic [15:0] e_q0;

    always @(negedge clock) begin
        e_busy = (m_cnt > 0);
        e_v0   = cs & !e_busy;
        e_q0   = e_v0 ? m_mem[address] : 16'hFFFF;
        check("busy0",    {15'd0, busy0}, {15'd0, e_busy});
        check("busy1",    {15'd0, busy1}, {15'd0, e_busy});
        check("q_valid0", {15'd0, qv0},   {15'd0, e_v0});
        check("q0",       q0,             e_q0);
        check("q_valid1", {15'd0, qv1},   {15'd0, m_qv1});
        check("q1",       q1,             m_q1);
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic count_busy(output int n);
        n = 0;
        while (busy0 && n < 100) begin
            tick();
            n++;
        end
    endtask

    task automatic rd0(input logic [3:0] a, input logic [15:0] exp, input string name);
        cs      = 1'b1;
        wren    = 1'b0;
        address = a;
        @(negedge clock);
        check(name, q0, exp);
    endtask

    int          n;
    logic [15:0] f3;

    initial begin
        check("model_w0", fill_fn(0), W0);
        check("model_w1", fill_fn(1), W1);
        check("model_w2", fill_fn(2), W2);
        check("model_w3", fill_fn(3), W3);

        repeat (3) tick();
        check("rst_busy",  {15'd0, busy0}, 16'd1);
        check("rst_q0",    q0,             16'hFFFF);
        check("rst_q1",    q1,             16'hFFFF);
        check("rst_qv1",   {15'd0, qv1},   16'd0);

        reset_n = 1'b1;
        count_busy(n);
        check("clear_len_reset", n[15:0], 16'd16);

        for (int a = 0; a < N; a++) rd0(a[3:0], fill_fn(a), "read_after_clear");
        rd0(4'd0, W0, "word0");

        // Byte-lane writes.
        f3      = fill_fn(3);
        cs = 1'b1; wren = 1'b1; address = 4'd3; data = 16'hBEEF; be = 2'b01;
        tick();
        rd0(4'd3, {f3[15:8], 8'hEF}, "be_low");
        tick();
        wren = 1'b1; be = 2'b10;
        tick();
        rd0(4'd3, 16'hBEEF, "be_high");
        tick();

        // Deselected: all-ones, no write.
        cs = 1'b0; wren = 1'b0; address = 4'd3;
        @(negedge clock);
        check("cs0_q",  q0,            16'hFFFF);
        check("cs0_qv", {15'd0, qv0},  16'd0);
        tick();
        cs = 1'b0; wren = 1'b1; be = 2'b11; data = 16'h1111;
        tick();
        rd0(4'd3, 16'hBEEF, "cs0_nowrite");
        tick();

        // Registered read is read-first.
        cs = 1'b1; wren = 1'b1; be = 2'b11; address = 4'd2; data = 16'h005A;
        tick();
        wren = 1'b0;
        @(negedge clock);
        check("read_first_old", q1, W2);
        tick();
        @(negedge clock);
        check("read_first_new", q1, 16'h005A);
        tick();

        // Restart a clear at clr_addr 7; host write during busy is dropped.
        clear_req = 1'b1; tick(); clear_req = 1'b0;
        repeat (7) tick();
        clear_req = 1'b1; tick(); clear_req = 1'b0;
        cs = 1'b1; wren = 1'b1; be = 2'b11; address = 4'd9; data = 16'h1234;
        tick();
        wren = 1'b0;
        count_busy(n);
        n = n + 1;
        check("clear_len_restart", n[15:0], 16'd16);
        rd0(4'd9, fill_fn(9), "busy_write_dropped");
        rd0(4'd3, W3, "restart_refill");
        tick();

        // Reset mid-clear at clr_addr 5.
        cs = 1'b1; wren = 1'b1; address = 4'd0; data = 16'h7777; be = 2'b11;
        tick();
        wren = 1'b0;
        clear_req = 1'b1; tick(); clear_req = 1'b0;
        repeat (5) tick();
        reset_n = 1'b0;
        #1;
        check("midclr_rst_q1",   q1,            16'hFFFF);
        check("midclr_rst_busy", {15'd0, busy0}, 16'd1);
        repeat (2) tick();
        reset_n = 1'b1;
        count_busy(n);
        check("clear_len_rerst", n[15:0], 16'd16);
        rd0(4'd0, W0, "rerst_word0");
        rd0(4'd1, W1, "rerst_word1");
        tick();

        // Randomized traffic with occasional clears.
        for (int i = 0; i < 800; i++) begin
            cs        = ($urandom_range(0, 3) != 0);
            wren      = $urandom_range(0, 1);
            be        = 2'($urandom_range(0, 3));
            address   = 4'($urandom_range(0, 15));
            data      = 16'($urandom);
            clear_req = ($urandom_range(0, 79) == 0);
            tick();
            clear_req = 1'b0;
        end

        wren = 1'b0;
        count_busy(n);
        check("final_idle", {15'd0, busy0}, 16'd0);
        for (int a = 0; a < N; a++) begin
            cs = 1'b1; address = a[3:0];
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
